// File: rtl/apb_stream_responder.sv
// APB completer bridging 8-bit register accesses onto a TX and an RX byte stream through two FIFOs.
// Blocked DATA accesses insert wait states, bounded by WAIT_MAX, after which they are forced to complete.
module apb_stream_responder #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PSEL,
    input  logic [7:0] PADDR,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [7:0]    WAIT_LIM = 8'(WAIT_MAX);

    localparam logic [7:0] ADDR_DATA    = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h01;
    localparam logic [7:0] ADDR_CONTROL = 8'h02;
    localparam logic [7:0] ADDR_SCRATCH = 8'h03;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q;
    logic [AW:0]   tx_cnt_q;
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_rptr_q;
    logic [AW:0]   rx_cnt_q;

    logic       tx_en_q, rx_en_q, timeout_err_q;
    logic [7:0] scratch_q;
    logic [0:0] state_q;
    logic [7:0] wait_cnt_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic access, is_data, blocked, timeout, done;
    logic tx_push, tx_pop, rx_push, rx_pop;

    always_comb begin
        tx_full  = (tx_cnt_q == FULL_CNT);
        tx_empty = (tx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FULL_CNT);
        rx_empty = (rx_cnt_q == '0);

        access  = PSEL & PENABLE;
        is_data = (PADDR == ADDR_DATA);
        // Flags are the registered pre-edge state, so a same-edge stream pop does not unblock.
        blocked = is_data & (PWRITE ? tx_full : rx_empty);
        timeout = (state_q == StWait) & blocked & (wait_cnt_q == WAIT_LIM);
        done    = RESETn & access & (~blocked | timeout);
        PREADY  = done;

        tx_push = done & PWRITE & is_data & ~timeout;
        rx_pop  = done & ~PWRITE & is_data & ~timeout;

        out_valid = RESETn & tx_en_q & ~tx_empty;
        out_data  = tx_mem[tx_rptr_q];
        tx_pop    = out_valid & out_ready;
        in_ready  = RESETn & rx_en_q & ~rx_full;
        rx_push   = in_valid & in_ready;
    end

    always_comb begin
        PRDATA = 8'h00;
        if (done && !PWRITE) begin
            case (PADDR)
                ADDR_DATA:    PRDATA = timeout ? 8'h00 : rx_mem[rx_rptr_q];
                ADDR_STATUS:  PRDATA = {3'b000, timeout_err_q, rx_empty, rx_full, tx_empty, tx_full};
                ADDR_CONTROL: PRDATA = {6'b000000, rx_en_q, tx_en_q};
                ADDR_SCRATCH: PRDATA = scratch_q;
                default:      PRDATA = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
        end else if (state_q == StIdle) begin
            if (access && blocked) begin
                state_q    <= StWait;
                wait_cnt_q <= 8'd1;
            end
        end else if (!access || done) begin
            // Completion, or the initiator abandoned the access mid-wait.
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            tx_en_q       <= 1'b1;
            rx_en_q       <= 1'b1;
            scratch_q     <= 8'h00;
            timeout_err_q <= 1'b0;
        end else begin
            if (done && PWRITE && PADDR == ADDR_CONTROL) begin
                tx_en_q <= PWDATA[0];
                rx_en_q <= PWDATA[1];
                if (PWDATA[7]) timeout_err_q <= 1'b0;
            end
            if (done && PWRITE && PADDR == ADDR_SCRATCH) scratch_q <= PWDATA;
            if (timeout) timeout_err_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
            tx_cnt_q <= tx_cnt_q + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
            rx_cnt_q <= rx_cnt_q + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wptr_q] <= PWDATA;
        if (rx_push) rx_mem[rx_wptr_q] <= in_data;
    end
endmodule

// File: tb/tb_apb_stream_responder.sv
// Directed bench for apb_stream_responder: register access, FIFO blocking, timeout, stream enables
// and reset during a wait state.
module tb_apb_stream_responder;
    logic       CLK = 1'b0;
    logic       RESETn;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PREADY;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic [7:0] in_data;
    logic       in_valid, in_ready;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] tx_seen[$];

    apb_stream_responder #(.DEPTH(4), .WAIT_MAX(15)) dut (
        .CLK(CLK), .RESETn(RESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (out_valid && out_ready) tx_seen.push_back(out_data);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One full APB transfer; waits = -1 if PREADY never arrives.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            output int waits, output logic [7:0] rdata);
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        rdata = 8'h00;
        forever begin
            @(negedge CLK);
            if (PREADY) begin
                rdata = PRDATA;
                break;
            end
            waits++;
            if (waits > 200) begin
                waits = -1;
                break;
            end
        end
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rx_push_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        in_data = b; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int w; logic [7:0] d;
        RESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h03;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        tests_run++; if (PREADY !== 1'b0) begin tests_failed++; $display("FAIL rst_pready: got %b want 0", PREADY); end
        tests_run++; if (PRDATA !== 8'h00) begin tests_failed++; $display("FAIL rst_prdata: got %h want 00", PRDATA); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; RESETn = 1'b1;
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (d !== 8'h0A) begin tests_failed++; $display("FAIL rst_status: got %h want 0a", d); end
        apb_xfer(1'b0, 8'h02, 8'h00, w, d);
        tests_run++; if (d !== 8'h03) begin tests_failed++; $display("FAIL rst_control: got %h want 03", d); end
        apb_xfer(1'b0, 8'h03, 8'h00, w, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL rst_scratch: got %h want 00", d); end
    endtask

    task automatic test_scratch();
        int w; logic [7:0] d;
        apb_xfer(1'b1, 8'h03, 8'hA5, w, d);
        tests_run++; if (w !== 0) begin tests_failed++; $display("FAIL scratch_wr_wait: got %0d want 0", w); end
        apb_xfer(1'b0, 8'h03, 8'h00, w, d);
        tests_run++; if (w !== 0) begin tests_failed++; $display("FAIL scratch_rd_wait: got %0d want 0", w); end
        tests_run++; if (d !== 8'hA5) begin tests_failed++; $display("FAIL scratch_rd: got %h want a5", d); end
        apb_xfer(1'b1, 8'h40, 8'hFF, w, d);
        tests_run++; if (w !== 0) begin tests_failed++; $display("FAIL unmapped_wr_wait: got %0d want 0", w); end
        apb_xfer(1'b0, 8'h40, 8'h00, w, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL unmapped_rd: got %h want 00", d); end
        apb_xfer(1'b0, 8'h03, 8'h00, w, d);
        tests_run++; if (d !== 8'hA5) begin tests_failed++; $display("FAIL scratch_kept: got %h want a5", d); end
    endtask

    task automatic test_tx_fifo();
        int w; logic [7:0] d;
        logic [7:0] exp_seq[5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h55};
        out_ready = 1'b0;
        tx_seen.delete();
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1'b1, 8'h00, 8'h11 + 8'(i), w, d);
            tests_run++; if (w !== 0) begin tests_failed++; $display("FAIL tx_wr%0d_wait: got %0d want 0", i, w); end
        end
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (d !== 8'h09) begin tests_failed++; $display("FAIL tx_full_status: got %h want 09", d); end
        // Fifth write blocks; stream is released after three wait cycles.
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h55;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests_run++; if (PREADY !== 1'b0) begin tests_failed++; $display("FAIL tx_wait%0d_pready: got %b want 0", i, PREADY); end
            tests_run++; if (out_data !== 8'h11) begin tests_failed++; $display("FAIL tx_hold%0d: got %h want 11", i, out_data); end
        end
        out_ready = 1'b1;
        @(negedge CLK);
        tests_run++; if (PREADY !== 1'b1) begin tests_failed++; $display("FAIL tx_release_pready: got %b want 1", PREADY); end
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (8) @(posedge CLK);
        #1 out_ready = 1'b0;
        tests_run++; if (tx_seen.size() !== 5) begin tests_failed++; $display("FAIL tx_count: got %0d want 5", tx_seen.size()); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (i >= tx_seen.size() || tx_seen[i] !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL tx_order%0d: got %h want %h", i, (i < tx_seen.size()) ? tx_seen[i] : 8'hxx, exp_seq[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int w; logic [7:0] d;
        in_valid = 1'b0;
        apb_xfer(1'b0, 8'h00, 8'h00, w, d);
        tests_run++; if (w !== 15) begin tests_failed++; $display("FAIL to_waits: got %0d want 15", w); end
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL to_rdata: got %h want 00", d); end
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (d !== 8'h1A) begin tests_failed++; $display("FAIL to_status_set: got %h want 1a", d); end
        apb_xfer(1'b1, 8'h02, 8'h83, w, d);
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (d !== 8'h0A) begin tests_failed++; $display("FAIL to_status_clr: got %h want 0a", d); end
        apb_xfer(1'b0, 8'h02, 8'h00, w, d);
        tests_run++; if (d !== 8'h03) begin tests_failed++; $display("FAIL to_control: got %h want 03", d); end
    endtask

    task automatic test_rx_fifo();
        int w; logic [7:0] d;
        rx_push_byte(8'h3C);
        rx_push_byte(8'h7E);
        apb_xfer(1'b0, 8'h00, 8'h00, w, d);
        tests_run++; if (w !== 0 || d !== 8'h3C) begin tests_failed++; $display("FAIL rx_rd0: got %h/%0d want 3c/0", d, w); end
        apb_xfer(1'b0, 8'h00, 8'h00, w, d);
        tests_run++; if (w !== 0 || d !== 8'h7E) begin tests_failed++; $display("FAIL rx_rd1: got %h/%0d want 7e/0", d, w); end
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (d !== 8'h0A) begin tests_failed++; $display("FAIL rx_empty_status: got %h want 0a", d); end
        for (int i = 0; i < 4; i++) rx_push_byte(8'h01 + 8'(i));
        @(negedge CLK);
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rx_full_ready: got %b want 0", in_ready); end
        rx_push_byte(8'h05);
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (d !== 8'h06) begin tests_failed++; $display("FAIL rx_full_status: got %h want 06", d); end
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1'b0, 8'h00, 8'h00, w, d);
            tests_run++; if (d !== 8'h01 + 8'(i)) begin tests_failed++; $display("FAIL rx_drain%0d: got %h want %h", i, d, 8'h01 + 8'(i)); end
        end
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (d !== 8'h0A) begin tests_failed++; $display("FAIL rx_drained_status: got %h want 0a", d); end
    endtask

    task automatic test_enable();
        int w; logic [7:0] d;
        out_ready = 1'b0;
        tx_seen.delete();
        apb_xfer(1'b1, 8'h00, 8'hA1, w, d);
        apb_xfer(1'b1, 8'h00, 8'hA2, w, d);
        apb_xfer(1'b1, 8'h02, 8'h00, w, d);
        @(negedge CLK);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL en_off_valid: got %b want 0", out_valid); end
        out_ready = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        tests_run++; if (tx_seen.size() !== 0) begin tests_failed++; $display("FAIL en_off_drain: got %0d want 0", tx_seen.size()); end
        apb_xfer(1'b1, 8'h02, 8'h01, w, d);
        repeat (4) @(posedge CLK);
        #1 out_ready = 1'b0;
        tests_run++; if (tx_seen.size() !== 2) begin tests_failed++; $display("FAIL en_on_count: got %0d want 2", tx_seen.size()); end
        tests_run++;
        if (tx_seen.size() != 2 || tx_seen[0] !== 8'hA1 || tx_seen[1] !== 8'hA2) begin
            tests_failed++;
            $display("FAIL en_on_order: got %p want a1,a2", tx_seen);
        end
        apb_xfer(1'b0, 8'h02, 8'h00, w, d);
        tests_run++; if (d !== 8'h01) begin tests_failed++; $display("FAIL en_control: got %h want 01", d); end
    endtask

    task automatic test_reset_in_wait();
        int w; logic [7:0] d;
        out_ready = 1'b0;
        apb_xfer(1'b1, 8'h00, 8'h77, w, d);
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        tests_run++; if (PREADY !== 1'b0) begin tests_failed++; $display("FAIL rw_pre_pready: got %b want 0", PREADY); end
        @(posedge CLK); #1;
        RESETn = 1'b0;
        @(negedge CLK);
        tests_run++; if (PREADY !== 1'b0) begin tests_failed++; $display("FAIL rw_rst_pready: got %b want 0", PREADY); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_rst_valid: got %b want 0", out_valid); end
        repeat (2) @(posedge CLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; RESETn = 1'b1;
        apb_xfer(1'b0, 8'h01, 8'h00, w, d);
        tests_run++; if (w !== 0 || d !== 8'h0A) begin tests_failed++; $display("FAIL rw_status: got %h/%0d want 0a/0", d, w); end
        apb_xfer(1'b0, 8'h02, 8'h00, w, d);
        tests_run++; if (d !== 8'h03) begin tests_failed++; $display("FAIL rw_control: got %h want 03", d); end
    endtask

    initial begin
        RESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 8'h00; out_ready = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        test_reset();
        test_scratch();
        test_tx_fifo();
        test_timeout();
        test_rx_fifo();
        test_enable();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
